// File: rtl/data_memory_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_responder_pkg
//
// Purpose:
//   Shared definitions for the data memory responder: the 32-bit machine word
//   type, the responder FSM state encoding, the response record returned to
//   the initiator, and the request validity check used at acceptance.
//
// Contents:
//   int_t                 32-bit data/address word
//   data_memory_state_t   IDLE / WAIT / RESPOND
//   response_t            { readData, error }
//   COUNTER_BITS          width of the latency countdown (LATENCY <= 7)
//   isRequestError()      misaligned or out-of-range byte address check
// -----------------------------------------------------------------------------
package data_memory_responder_pkg;

  typedef logic [31:0] int_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } data_memory_state_t;

  typedef struct packed {
    int_t readData;
    logic error;
  } response_t;

  // LATENCY is at most 7, so the countdown (LATENCY-1) fits in three bits.
  localparam int unsigned COUNTER_BITS = 3;

  // A request is in error when the byte address is not word aligned or when
  // its word number (address >> 2) lies at or beyond the array depth. Checking
  // that every bit above the word index is zero is the same as comparing the
  // word number against a power-of-two depth.
  function automatic logic isRequestError(input int_t address,
                                          input int unsigned wordIndexBits);
    logic misaligned;
    logic outOfRange;
    misaligned = (address[1:0] != 2'b00);
    outOfRange = ((address >> (wordIndexBits + 32'd2)) != 32'd0);
    return misaligned || outOfRange;
  endfunction

endpackage

// File: rtl/data_memory_responder_array.sv
// -----------------------------------------------------------------------------
// data_memory_responder_array
//
// Purpose:
//   Single-port word storage for the data memory responder. Writes are
//   synchronous; the read port is combinational so the responder can capture
//   the word on the same edge that commits a pending store.
//   Contents are never cleared: the array has no reset by design.
//
// Parameters:
//   DEPTH_WORDS   number of 32-bit words (power of two)
//
// Ports:
//   clock         write clock
//   writeEnable   commit writeData to word `index` on this posedge
//   index         word index shared by the read and write port
//   writeData     word to store
//   readData      current contents of word `index`
// -----------------------------------------------------------------------------
module data_memory_responder_array #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int INDEX_BITS  = $clog2(DEPTH_WORDS)
) (
  input  logic                  clock,
  input  logic                  writeEnable,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData
);

  logic [31:0] memory [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (writeEnable) begin
      memory[index] <= writeData;
    end
  end

  assign readData = memory[index];

endmodule

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//
// Purpose:
//   Fixed-latency load/store responder in front of a word array. One request
//   is in flight at a time: it is accepted in IDLE, waits LATENCY cycles in
//   WAIT, then is presented in RESPOND until the initiator consumes it.
//   Stores commit on the edge that enters RESPOND; loads capture the word on
//   that same edge. Misaligned or out-of-range requests report an error,
//   return zero data and never touch the array.
//
// Parameters:
//   DEPTH_WORDS   number of 32-bit words (power of two, 16..65536)
//   LATENCY       edges from acceptance to respValid (1..7)
//
// Ports:
//   clock         sole clock, all state on posedge
//   reset         synchronous, active-low
//   reqValid      initiator presents a request
//   reqReady      responder accepts a request this cycle (IDLE only)
//   reqWrite      1 = store, 0 = load
//   reqAddress    byte address
//   reqWriteData  store data
//   respValid     response available (RESPOND only)
//   respReady     initiator consumes the response
//   respReadData  load data, 0 for stores and errors
//   respError     request was misaligned or out of range
// -----------------------------------------------------------------------------
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respReadData,
  output logic        respError
);

  localparam int INDEX_BITS = $clog2(DEPTH_WORDS);

  // Countdown value loaded at acceptance. WAIT is always visited, and RESPOND
  // is entered on the edge where the counter is already zero, so LATENCY==1
  // spends a single WAIT cycle with the counter at zero.
  localparam logic [COUNTER_BITS-1:0] COUNTER_LOAD = COUNTER_BITS'(LATENCY - 1);

  data_memory_state_t      stateReg;
  logic [COUNTER_BITS-1:0] counterReg;
  logic                    writeReg;
  logic                    errorReg;
  logic [INDEX_BITS-1:0]   wordIndexReg;
  int_t                    writeDataReg;
  response_t               responseReg;

  int_t                    arrayReadData;
  logic                    enteringRespond;
  logic                    commitStore;

  // The edge leaving WAIT is the single point where a store is committed and
  // a load is sampled. Gating with reset discards a store whose commit edge
  // coincides with reset being asserted.
  assign enteringRespond = reset && (stateReg == WAIT) && (counterReg == '0);
  assign commitStore     = enteringRespond && writeReg && !errorReg;

  data_memory_responder_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) memoryArray (
    .clock       (clock),
    .writeEnable (commitStore),
    .index       (wordIndexReg),
    .writeData   (writeDataReg),
    .readData    (arrayReadData)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      stateReg     <= IDLE;
      counterReg   <= '0;
      writeReg     <= 1'b0;
      errorReg     <= 1'b0;
      wordIndexReg <= '0;
      writeDataReg <= '0;
      responseReg  <= '0;
      reqReady     <= 1'b1;
      respValid    <= 1'b0;
    end else begin
      unique case (stateReg)
        IDLE: begin
          // reqReady is high throughout IDLE, so reqValid alone is the handshake.
          if (reqValid) begin
            writeReg     <= reqWrite;
            errorReg     <= isRequestError(reqAddress, INDEX_BITS);
            wordIndexReg <= reqAddress[2 +: INDEX_BITS];
            writeDataReg <= reqWriteData;
            counterReg   <= COUNTER_LOAD;
            reqReady     <= 1'b0;
            stateReg     <= WAIT;
          end
        end

        WAIT: begin
          if (counterReg == '0) begin
            responseReg.error    <= errorReg;
            // Stores and errored requests answer with zero data; the read
            // port still shows the pre-commit contents on this edge.
            responseReg.readData <= (writeReg || errorReg) ? '0 : arrayReadData;
            respValid            <= 1'b1;
            stateReg             <= RESPOND;
          end else begin
            counterReg <= counterReg - 1'b1;
          end
        end

        RESPOND: begin
          // Response stays frozen until consumed; reqReady only rises on the
          // following edge, so nothing is accepted in the consuming cycle.
          if (respReady) begin
            responseReg <= '0;
            respValid   <= 1'b0;
            reqReady    <= 1'b1;
            stateReg    <= IDLE;
          end
        end

        default: begin
          stateReg  <= IDLE;
          reqReady  <= 1'b1;
          respValid <= 1'b0;
        end
      endcase
    end
  end

  assign respReadData = responseReg.readData;
  assign respError    = responseReg.error;

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
//
// Three responders share one clock and reset: index 0 uses LATENCY=2,
// index 1 LATENCY=1, index 2 LATENCY=7, all with DEPTH_WORDS=1024.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int N = 3;

  logic clock = 1'b0;
  logic reset;

  logic reqValidV [N];
  logic reqReadyV [N];
  logic reqWriteV [N];
  logic respValidV [N];
  logic respReadyV [N];
  logic respErrorV [N];
  int_t reqAddressV [N];
  int_t reqWriteDataV [N];
  int_t respReadDataV [N];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 7);
      data_memory_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT)
      ) dut (
        .clock        (clock),
        .reset        (reset),
        .reqValid     (reqValidV[gi]),
        .reqReady     (reqReadyV[gi]),
        .reqWrite     (reqWriteV[gi]),
        .reqAddress   (reqAddressV[gi]),
        .reqWriteData (reqWriteDataV[gi]),
        .respValid    (respValidV[gi]),
        .respReady    (respReadyV[gi]),
        .respReadData (respReadDataV[gi]),
        .respError    (respErrorV[gi])
      );
    end
  endgenerate

  // Issues one request on responder idx starting #1 after a posedge, waits
  // (bounded) for the response, records it and consumes it. lat is the number
  // of edges from the accepting edge to respValid, or -1 on timeout.
  task automatic doRequest(input int idx, input logic w, input int_t a, input int_t d,
                           output int acceptWait, output int lat,
                           output int_t rd, output logic re);
    reqValidV[idx]     = 1'b1;
    reqWriteV[idx]     = w;
    reqAddressV[idx]   = a;
    reqWriteDataV[idx] = d;
    respReadyV[idx]    = 1'b0;
    acceptWait = 0;
    while (reqReadyV[idx] !== 1'b1 && acceptWait < 20) begin
      @(posedge clock); #1;
      acceptWait++;
    end
    @(posedge clock); #1;
    reqValidV[idx] = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (lat < 0) begin
        @(posedge clock); #1;
        if (respValidV[idx] === 1'b1) lat = c;
      end
    end
    rd = respReadDataV[idx];
    re = respErrorV[idx];
    $display("txn dut%0d %s addr=%h wdata=%h -> latency=%0d rdata=%h error=%b",
             idx, w ? "store" : "load ", a, d, lat, rd, re);
    respReadyV[idx] = 1'b1;
    @(posedge clock); #1;
    respReadyV[idx] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (respValidV[i] !== 1'b0) begin
        failures++; $display("FAIL reset_respValid dut%0d: got %b expected 0", i, respValidV[i]);
      end
      checks++;
      if (respReadDataV[i] !== 32'h0) begin
        failures++; $display("FAIL reset_respReadData dut%0d: got %h expected 0", i, respReadDataV[i]);
      end
      checks++;
      if (respErrorV[i] !== 1'b0) begin
        failures++; $display("FAIL reset_respError dut%0d: got %b expected 0", i, respErrorV[i]);
      end
    end
    reset = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (reqReadyV[i] !== 1'b1) begin
        failures++; $display("FAIL reset_reqReady dut%0d: got %b expected 1", i, reqReadyV[i]);
      end
    end
  endtask

  task automatic test_store_load();
    int aw, lat; int_t rd; logic re;
    doRequest(0, 1'b1, 32'h10, 32'h1234_5678, aw, lat, rd, re);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL store_latency: got %0d expected 2", lat); end
    checks++;
    if (re !== 1'b0) begin failures++; $display("FAIL store_error: got %b expected 0", re); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL store_data: got %h expected 00000000", rd); end
    doRequest(0, 1'b1, 32'h14, 32'hCAFE_F00D, aw, lat, rd, re);
    doRequest(0, 1'b0, 32'h10, 32'h0, aw, lat, rd, re);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL load_latency: got %0d expected 2", lat); end
    checks++;
    if (rd !== 32'h1234_5678) begin failures++; $display("FAIL load_0x10: got %h expected 12345678", rd); end
    checks++;
    if (re !== 1'b0) begin failures++; $display("FAIL load_error: got %b expected 0", re); end
    doRequest(0, 1'b0, 32'h14, 32'h0, aw, lat, rd, re);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL load_0x14: got %h expected cafef00d", rd); end
  endtask

  task automatic test_errors();
    int aw, lat; int_t rd; logic re;
    doRequest(0, 1'b0, 32'h13, 32'h0, aw, lat, rd, re);
    checks++;
    if (re !== 1'b1) begin failures++; $display("FAIL misaligned_load_error: got %b expected 1", re); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL misaligned_load_data: got %h expected 00000000", rd); end
    doRequest(0, 1'b0, 32'h10, 32'h0, aw, lat, rd, re);
    checks++;
    if (rd !== 32'h1234_5678) begin failures++; $display("FAIL after_misaligned_load: got %h expected 12345678", rd); end

    doRequest(0, 1'b1, 32'h400, 32'hA5A5_A5A5, aw, lat, rd, re);
    doRequest(0, 1'b1, 32'h402, 32'hDEAD_BEEF, aw, lat, rd, re);
    checks++;
    if (re !== 1'b1) begin failures++; $display("FAIL misaligned_store_error: got %b expected 1", re); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL error_latency: got %0d expected 2", lat); end
    doRequest(0, 1'b0, 32'h400, 32'h0, aw, lat, rd, re);
    checks++;
    if (rd !== 32'hA5A5_A5A5) begin failures++; $display("FAIL misaligned_store_nowrite: got %h expected a5a5a5a5", rd); end

    // Word 1024 would alias onto word 0 if the range check were missing.
    doRequest(0, 1'b1, 32'h0, 32'h0F0F_0F0F, aw, lat, rd, re);
    doRequest(0, 1'b1, 32'h1000, 32'hBADB_AD00, aw, lat, rd, re);
    checks++;
    if (re !== 1'b1) begin failures++; $display("FAIL range_store_error: got %b expected 1", re); end
    doRequest(0, 1'b0, 32'h0, 32'h0, aw, lat, rd, re);
    checks++;
    if (rd !== 32'h0F0F_0F0F) begin failures++; $display("FAIL range_store_nowrite: got %h expected 0f0f0f0f", rd); end

    doRequest(0, 1'b1, 32'hFFC, 32'h600D_CAFE, aw, lat, rd, re);
    checks++;
    if (re !== 1'b0) begin failures++; $display("FAIL last_word_store_error: got %b expected 0", re); end
    doRequest(0, 1'b0, 32'hFFC, 32'h0, aw, lat, rd, re);
    checks++;
    if (rd !== 32'h600D_CAFE || re !== 1'b0) begin
      failures++; $display("FAIL last_word_load: got %h/%b expected 600dcafe/0", rd, re);
    end
  endtask

  task automatic test_hold_response();
    int aw, lat, waited; int_t rd; logic re;
    reqValidV[0] = 1'b1; reqWriteV[0] = 1'b0; reqAddressV[0] = 32'h10; reqWriteDataV[0] = 32'h0;
    respReadyV[0] = 1'b0;
    @(posedge clock); #1;
    // A second request (a store to the same word) is held for the whole time.
    reqWriteV[0] = 1'b1; reqWriteDataV[0] = 32'h0BAD_0BAD;
    waited = 0;
    while (respValidV[0] !== 1'b1 && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    checks++;
    if (waited !== 2) begin failures++; $display("FAIL hold_latency: got %0d expected 2", waited); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      checks++;
      if (respValidV[0] !== 1'b1 || respReadDataV[0] !== 32'h1234_5678 || respErrorV[0] !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable cycle %0d: got valid=%b data=%h err=%b expected 1/12345678/0",
                 k, respValidV[0], respReadDataV[0], respErrorV[0]);
      end
      checks++;
      if (reqReadyV[0] !== 1'b0) begin
        failures++; $display("FAIL hold_reqReady cycle %0d: got %b expected 0", k, reqReadyV[0]);
      end
    end
    respReadyV[0] = 1'b1;
    @(posedge clock); #1;
    respReadyV[0] = 1'b0;
    reqValidV[0]  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (respValidV[0] !== 1'b0 || reqReadyV[0] !== 1'b1) begin
      failures++; $display("FAIL hold_no_accept: got valid=%b ready=%b expected 0/1", respValidV[0], reqReadyV[0]);
    end
    doRequest(0, 1'b0, 32'h10, 32'h0, aw, lat, rd, re);
    checks++;
    if (rd !== 32'h1234_5678) begin failures++; $display("FAIL hold_store_ignored: got %h expected 12345678", rd); end
  endtask

  task automatic test_back_to_back();
    int aw, lat; int_t rd; logic re;
    doRequest(0, 1'b1, 32'h18, 32'hB0B0_0001, aw, lat, rd, re);
    checks++;
    if (reqReadyV[0] !== 1'b1) begin failures++; $display("FAIL b2b_reqReady: got %b expected 1", reqReadyV[0]); end
    checks++;
    if (respValidV[0] !== 1'b0) begin failures++; $display("FAIL b2b_respValid_drop: got %b expected 0", respValidV[0]); end
    doRequest(0, 1'b0, 32'h18, 32'h0, aw, lat, rd, re);
    checks++;
    if (aw !== 0) begin failures++; $display("FAIL b2b_accept_wait: got %0d expected 0", aw); end
    checks++;
    if (lat !== 2 || rd !== 32'hB0B0_0001) begin
      failures++; $display("FAIL b2b_load: got lat=%0d data=%h expected 2/b0b00001", lat, rd);
    end
  endtask

  task automatic test_reset_abort();
    int aw, lat, waited; int_t rd; logic re;
    doRequest(0, 1'b1, 32'h20, 32'h1111_2222, aw, lat, rd, re);
    reqValidV[0] = 1'b1; reqWriteV[0] = 1'b1; reqAddressV[0] = 32'h20; reqWriteDataV[0] = 32'h3333_4444;
    @(posedge clock); #1;
    reqValidV[0] = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (respValidV[0] !== 1'b0 || respReadDataV[0] !== 32'h0 || respErrorV[0] !== 1'b0) begin
      failures++; $display("FAIL abort_outputs: got %b/%h/%b expected 0/0/0", respValidV[0], respReadDataV[0], respErrorV[0]);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (reqReadyV[0] !== 1'b1) begin failures++; $display("FAIL abort_reqReady: got %b expected 1", reqReadyV[0]); end
    doRequest(0, 1'b0, 32'h20, 32'h0, aw, lat, rd, re);
    checks++;
    if (rd !== 32'h1111_2222) begin failures++; $display("FAIL abort_store_discarded: got %h expected 11112222", rd); end

    // Reset while a load response with nonzero data is being held.
    reqValidV[0] = 1'b1; reqWriteV[0] = 1'b0; reqAddressV[0] = 32'h20;
    @(posedge clock); #1;
    reqValidV[0] = 1'b0;
    waited = 0;
    while (respValidV[0] !== 1'b1 && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (respValidV[0] !== 1'b0 || respReadDataV[0] !== 32'h0) begin
      failures++; $display("FAIL respond_reset_outputs: got %b/%h expected 0/00000000", respValidV[0], respReadDataV[0]);
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_latency_variants();
    int aw, lat; int_t rd; logic re;
    doRequest(1, 1'b1, 32'h8, 32'h5555_AAAA, aw, lat, rd, re);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL lat1_store_latency: got %0d expected 1", lat); end
    doRequest(1, 1'b0, 32'h8, 32'h0, aw, lat, rd, re);
    checks++;
    if (lat !== 1 || rd !== 32'h5555_AAAA) begin
      failures++; $display("FAIL lat1_load: got lat=%0d data=%h expected 1/5555aaaa", lat, rd);
    end
    doRequest(2, 1'b1, 32'hFFC, 32'h0000_7777, aw, lat, rd, re);
    checks++;
    if (lat !== 7) begin failures++; $display("FAIL lat7_store_latency: got %0d expected 7", lat); end
    doRequest(2, 1'b0, 32'hFFC, 32'h0, aw, lat, rd, re);
    checks++;
    if (lat !== 7 || rd !== 32'h0000_7777) begin
      failures++; $display("FAIL lat7_load: got lat=%0d data=%h expected 7/00007777", lat, rd);
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      reqValidV[i] = 1'b0; reqWriteV[i] = 1'b0; reqAddressV[i] = '0;
      reqWriteDataV[i] = '0; respReadyV[i] = 1'b0;
    end
    test_reset();
    test_store_load();
    test_errors();
    test_hold_response();
    test_back_to_back();
    test_reset_abort();
    test_latency_variants();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: DataMemoryResponder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response valid (1..7).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 sampled at posedge resets the block).
REQ-005 SHALL have port reqValid  input  1  initiator presents a request.
REQ-006 SHALL have port reqReady  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port reqWrite  input  1  1=store, 0=load.
REQ-008 SHALL have port reqAddress  input  32  byte address (int_t).
REQ-009 SHALL have port reqWriteData  input  32  store data (int_t).
REQ-010 SHALL have port respValid  output  1  response available.
REQ-011 SHALL have port respReady  input  1  initiator consumes response.
REQ-012 SHALL have port respReadData  output  32  load data; 0 for stores and errors.
REQ-013 SHALL have port respError  output  1  request was misaligned or out of range.

Function
REQ-014 SHALL accept a request on a posedge where reqValid && reqReady, latching write, address, data.
REQ-015 SHALL implement FSM states IDLE, WAIT, RESPOND; reqReady=1 only in IDLE.
REQ-016 IDLE->WAIT on acceptance; latency counter loads LATENCY-1; LATENCY==1 goes IDLE->RESPOND directly.
REQ-017 WAIT decrements counter each cycle; counter==0 -> RESPOND next cycle, so respValid rises exactly LATENCY cycles after acceptance.
REQ-018 RESPOND holds respValid=1 and respReadData/respError stable until respReady==1; then ->IDLE; no new acceptance in that same cycle.
REQ-019 SHALL index words by reqAddress[2 +: log2(DEPTH_WORDS)].
REQ-020 SHALL flag error when reqAddress[1:0]!=0 or reqAddress>>2 >= DEPTH_WORDS; errored requests never modify memory and return data 0.
REQ-021 Store SHALL commit to memory on the posedge entering RESPOND, never earlier, exactly once.
REQ-022 Load SHALL return the word contents at the posedge entering RESPOND (includes any prior committed store to the same word).
REQ-023 reqValid while reqReady==0 SHALL be ignored; initiator holds request until accepted.
REQ-024 respValid SHALL be 0 in IDLE and WAIT.

Reset
REQ-025 On reset: state=IDLE, counter=0, reqReady=1 on the following cycle, respValid=0, respReadData=0, respError=0.
REQ-026 Reset during WAIT or RESPOND SHALL abort the request; an uncommitted store is discarded.
REQ-027 Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-028 data_memory_state_t enum (IDLE/WAIT/RESPOND) and response struct (readData, error) SHALL live in Definitions.sv alongside int_t.
REQ-029 Storage array SHALL be a sub-module DataMemoryArray (single-port, synchronous write, combinational read) instantiated once.

Verification
REQ-030 LATENCY=2: store 0x1234_5678 @0x10 accepted cycle 0 -> respValid cycle 2, error=0, data=0; later load @0x10 -> 0x1234_5678.
REQ-031 Load @0x13 -> respError=1, respReadData=0; memory unchanged; store @0x402 with DEPTH_WORDS=1024 ->  error, no write.
REQ-032 Hold respReady=0 for 5 cycles in RESPOND -> respValid and data stable, reqReady=0, second reqValid not accepted.
REQ-033 Back-to-back: respReady=1 same cycle as response -> reqReady=1 next cycle; next request accepted then.
REQ-034 Assert reset=0 in WAIT of a store to 0x20 -> after reset, load 0x20 returns prior value; outputs zero during reset.
REQ-035 LATENCY=1 and LATENCY=7: respValid rises exactly 1 and 7 cycles after acceptance respectively.
